// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its two-requester arbiter:
// widths, opcode encoding and the arbiter FSM state encoding.
package alu_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_OP_W   = 3;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_SLL = 3'b010;
  localparam logic [2:0] OP_SRL = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;
  localparam logic [2:0] OP_EQL = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between two ALU requesters, the arbiter and the
// response consumer.
// Handshake: a transfer happens on a rising clk edge where valid and ready are
// both high; ready may depend combinationally on valid, valid never on ready,
// and a source holds its payload stable while valid is high and ready is low.
interface alu_arbiter_if
  import alu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int OP_W   = DEF_OP_W
);

  logic              req0_valid;
  logic              req0_ready;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;
  logic [OP_W-1:0]   req0_op;

  logic              req1_valid;
  logic              req1_ready;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;
  logic [OP_W-1:0]   req1_op;

  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_data;
  logic              resp_id;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    input  resp_ready,
    output req0_ready, req1_ready,
    output resp_valid, resp_data, resp_id
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    output resp_ready,
    input  req0_ready, req1_ready,
    input  resp_valid, resp_data, resp_id
  );

endinterface

// File: rtl/alu_arbiter_alu.sv
// Purely combinational 8-bit ALU shared by the arbiter's requesters.
// Shifts move a by one place and ignore b; EQL yields 1 or 0.
module alu_arbiter_alu
  import alu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int OP_W   = DEF_OP_W
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [OP_W-1:0]   op,
  output logic [DATA_W-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_SLL:  y = a << 1;
      OP_SRL:  y = a >> 1;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_EQL:  y = {{(DATA_W-1){1'b0}}, (a == b)};
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters; results return
// on a single response channel tagged with the requester id.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int OP_W   = DEF_OP_W
) (
  input  logic         clk,
  input  logic         rst,
  alu_arbiter_if.slave bus,
  output state_t       dbg_state
);

  state_t            state_q;
  state_t            state_d;

  logic              grant_valid;
  logic              grant_id;
  logic              ready0;
  logic              ready1;
  logic              accept;

  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [OP_W-1:0]   op_q;
  logic              id_q;
  logic              last_grant_q;

  logic [DATA_W-1:0] alu_y;
  logic              resp_valid_q;
  logic [DATA_W-1:0] resp_data_q;
  logic              resp_id_q;

  // Under contention the requester that did not win last time goes next.
  always_comb begin
    grant_valid = bus.req0_valid | bus.req1_valid;
    if (bus.req0_valid && bus.req1_valid) begin
      grant_id = ~last_grant_q;
    end else begin
      grant_id = bus.req1_valid;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_EXEC;
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: if (bus.resp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ready0 = 1'b0;
    ready1 = 1'b0;
    if (state_q == ST_IDLE && grant_valid) begin
      ready0 = ~grant_id;
      ready1 = grant_id;
    end
    accept = ready0 | ready1;
  end

  // Operands are captured once at acceptance; the ALU only ever sees these.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
    end else if (accept) begin
      a_q          <= grant_id ? bus.req1_a  : bus.req0_a;
      b_q          <= grant_id ? bus.req1_b  : bus.req0_b;
      op_q         <= grant_id ? bus.req1_op : bus.req0_op;
      id_q         <= grant_id;
      last_grant_q <= grant_id;
    end
  end

  alu_arbiter_alu #(
    .DATA_W (DATA_W),
    .OP_W   (OP_W)
  ) u_alu (
    .a  (a_q),
    .b  (b_q),
    .op (op_q),
    .y  (alu_y)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_id_q    <= 1'b0;
    end else if (state_q == ST_EXEC) begin
      resp_valid_q <= 1'b1;
      resp_data_q  <= alu_y;
      resp_id_q    <= id_q;
    end else if (state_q == ST_RESP && bus.resp_ready) begin
      resp_valid_q <= 1'b0;
    end
  end

  assign bus.req0_ready = ready0;
  assign bus.req1_ready = ready1;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_id    = resp_id_q;
  assign dbg_state      = state_q;

endmodule
